// File: rtl/simd_issue_ctrl.sv
// Command-driven issue sequencer for simd_top_level: configures the datapath,
// streams buffered operand pairs one per cycle, drains the pipeline and reports done.
module simd_issue_ctrl #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_opa,
  input  logic [DATA_W-1:0] ld_opb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [5:0]        cmd_len,
  input  logic              hold,
  output logic              valid_instruction,
  output logic [2:0]        instruction,
  output logic [5:0]        data_size,
  output logic              valid_data,
  output logic [DATA_W-1:0] mc_data_in_opa,
  output logic [DATA_W-1:0] mc_data_in_opb,
  output logic [5:0]        issue_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [5:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   drain_q, drain_d;
  logic [DATA_W-1:0]  mem_a [DEPTH];
  logic [DATA_W-1:0]  mem_b [DEPTH];

  logic               ld_ready_d, cmd_ready_d, valid_instruction_d, valid_data_d;
  logic               busy_d, done_d, err_d;
  logic [2:0]         instruction_d;
  logic [5:0]         data_size_d, issue_idx_d;
  logic [DATA_W-1:0]  opa_d, opb_d;

  // Operand buffer: not reset, writable only while idle
  always_ff @(posedge clk) begin
    if (ld_valid && ld_ready) begin
      mem_a[ld_addr] <= ld_opa;
      mem_b[ld_addr] <= ld_opb;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      ptr_q             <= '0;
      drain_q           <= '0;
      ld_ready          <= 1'b1;
      cmd_ready         <= 1'b1;
      valid_instruction <= 1'b0;
      instruction       <= '0;
      data_size         <= '0;
      valid_data        <= 1'b0;
      mc_data_in_opa    <= '0;
      mc_data_in_opb    <= '0;
      issue_idx         <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      drain_q           <= drain_d;
      ld_ready          <= ld_ready_d;
      cmd_ready         <= cmd_ready_d;
      valid_instruction <= valid_instruction_d;
      instruction       <= instruction_d;
      data_size         <= data_size_d;
      valid_data        <= valid_data_d;
      mc_data_in_opa    <= opa_d;
      mc_data_in_opb    <= opb_d;
      issue_idx         <= issue_idx_d;
      busy              <= busy_d;
      done              <= done_d;
      err               <= err_d;
    end
  end

  // Next state; STREAM ends once ptr reaches the latched length
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_valid && cmd_ready && (cmd_len != 6'd0)) state_d = S_CFG;
      S_CFG:    state_d = S_STREAM;
      S_STREAM: if (ptr_q == data_size) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output next values; a beat is launched at every non-held edge leaving CFG/STREAM
  always_comb begin
    ptr_d               = ptr_q;
    drain_d             = '0;
    instruction_d       = instruction;
    data_size_d         = data_size;
    issue_idx_d         = issue_idx;
    opa_d               = mc_data_in_opa;
    opb_d               = mc_data_in_opb;
    valid_data_d        = 1'b0;
    cmd_ready_d         = (state_d == S_IDLE);
    ld_ready_d          = (state_d == S_IDLE);
    busy_d              = (state_d != S_IDLE);
    done_d              = (state_d == S_DONE);
    valid_instruction_d = (state_d == S_CFG) || (state_d == S_STREAM);
    err_d               = (state_q == S_IDLE) && cmd_valid && cmd_ready && (cmd_len == 6'd0);

    if ((state_q == S_IDLE) && (state_d == S_CFG)) begin
      instruction_d = cmd_op;
      data_size_d   = cmd_len;
      ptr_d         = '0;
    end

    if (((state_q == S_CFG) || (state_q == S_STREAM)) && (ptr_q != data_size) && !hold) begin
      valid_data_d = 1'b1;
      opa_d        = mem_a[ADDR_W'(ptr_q)];
      opb_d        = mem_b[ADDR_W'(ptr_q)];
      issue_idx_d  = ptr_q;
      ptr_d        = ptr_q + 6'd1;
    end

    if (state_q == S_DRAIN) drain_d = drain_q + CNT_W'(1);
  end

endmodule
